// File: rtl/pipeline_stall_scheduler.sv
// Load-use and mult/div hazard scheduler for the 5-stage MIPS pipeline.
// Optional stall statistics counter enabled by defining STALL_STATS_EN.
module pipeline_stall_scheduler #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_regDst,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             muldiv_start,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } MdState;

    localparam logic [3:0] BusyLoad = 4'(MULDIV_LATENCY - 1);

    MdState     state;
    logic [3:0] busyCnt;
    logic       luHazard;
    logic       mdHazard;

    assign luHazard = id_valid & ex_memRead & (ex_regDst != 5'd0) &
                      ((ex_regDst == id_rs) | (id_uses_rt & (ex_regDst == id_rt)));
    assign mdHazard = id_valid & muldiv_busy & (id_reads_hilo | id_is_muldiv);

    // A taken branch kills the ID instruction, so it outranks any hazard on it.
    always_comb begin
        stall        = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        muldiv_start = 1'b0;
        if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (luHazard | mdHazard) begin
            stall        = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (id_valid & id_is_muldiv & (state == IDLE)) begin
            muldiv_start = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            busyCnt     <= 4'd0;
            muldiv_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (muldiv_start) begin
                        state       <= BUSY;
                        busyCnt     <= BusyLoad;
                        muldiv_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (busyCnt == 4'd0) begin
                        state       <= IDLE;
                        muldiv_busy <= 1'b0;
                    end else begin
                        busyCnt <= busyCnt - 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    muldiv_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_STATS_EN
    // Saturating so a long-running profile never reads back a small value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_scheduler.sv
// Scoreboard bench for pipeline_stall_scheduler: driver queues expected outputs,
// a monitor pops and compares them each cycle.
module tb_pipeline_stall_scheduler;

    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs = 5'd0;
    logic [4:0]       id_rt = 5'd0;
    logic             id_uses_rt = 1'b0;
    logic             id_is_muldiv = 1'b0;
    logic             id_reads_hilo = 1'b0;
    logic             ex_memRead = 1'b0;
    logic [4:0]       ex_regDst = 5'd0;
    logic             ex_branch_taken = 1'b0;
    logic             stall;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             muldiv_start;
    logic             muldiv_busy;
    logic [CNT_W-1:0] stall_count;

    int checkCount = 0;
    int errorCount = 0;

    logic [4:0]       outQ[$];
    logic [CNT_W-1:0] cntQ[$];
    string            nameQ[$];

    logic [CNT_W-1:0] expCount = '0;
    bit               quiet = 1'b0;

    pipeline_stall_scheduler #(.MULDIV_LATENCY(4), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .ex_memRead(ex_memRead), .ex_regDst(ex_regDst), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy), .stall_count(stall_count)
    );

    always #5 Clk = ~Clk;

    // expOuts = {stall, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy}
    task automatic applyStimulus(input string name, input logic rst, input logic valid,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic isMd, input logic readsHilo, input logic memRead,
                                 input logic [4:0] regDst, input logic branch,
                                 input logic [4:0] expOuts);
        @(posedge Clk);
        #1;
        Rst = rst; id_valid = valid; id_rs = rs; id_rt = rt; id_uses_rt = usesRt;
        id_is_muldiv = isMd; id_reads_hilo = readsHilo; ex_memRead = memRead;
        ex_regDst = regDst; ex_branch_taken = branch;
        if (!quiet) begin
            outQ.push_back(expOuts);
            cntQ.push_back(expCount);
            nameQ.push_back(name);
        end
`ifdef STALL_STATS_EN
        if (rst) expCount = '0;
        else if (expOuts[4] && expCount != {CNT_W{1'b1}}) expCount = expCount + 1'b1;
`endif
    endtask

    task automatic checkOutput();
        logic [4:0]       expOuts;
        logic [CNT_W-1:0] expCnt;
        logic [4:0]       actOuts;
        string            name;
        expOuts = outQ.pop_front();
        expCnt  = cntQ.pop_front();
        name    = nameQ.pop_front();
        actOuts = {stall, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy};
        checkCount++;
        if (actOuts !== expOuts) begin
            errorCount++;
            $display("[TB] FAIL %s outs{stall,bubble,flush,start,busy} got %b want %b", name, actOuts, expOuts);
        end
        checkCount++;
        if (stall_count !== expCnt) begin
            errorCount++;
            $display("[TB] FAIL %s_count got %0d want %0d", name, stall_count, expCnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (outQ.size() > 0) checkOutput();
        end
    end

    initial begin
        repeat (2) @(posedge Clk);
        //              name            rst v  rs  rt u md hl mr dst br  expected
        applyStimulus("reset",          1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
        applyStimulus("idle",           0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
        applyStimulus("luRs",           0, 1, 8,  0, 0, 0, 0, 1, 8,  0, 5'b11000);
        applyStimulus("luRelease",      0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
        applyStimulus("luZeroDst",      0, 1, 0,  0, 0, 0, 0, 1, 0,  0, 5'b00000);
        applyStimulus("rtGated",        0, 1, 1,  9, 0, 0, 0, 1, 9,  0, 5'b00000);
        applyStimulus("rtUsed",         0, 1, 1,  9, 1, 0, 0, 1, 9,  0, 5'b11000);
        applyStimulus("multIssue",      0, 1, 0,  0, 0, 1, 0, 0, 0,  0, 5'b00010);
        for (int i = 0; i < 4; i++)
            applyStimulus("mfloStall",  0, 1, 0,  0, 0, 0, 1, 0, 0,  0, 5'b11001);
        applyStimulus("mfloIssue",      0, 1, 0,  0, 0, 0, 1, 0, 0,  0, 5'b00000);
        applyStimulus("luRt",           0, 1, 0,  5, 1, 0, 0, 1, 5,  0, 5'b11000);
        applyStimulus("branchPri",      0, 1, 8,  0, 0, 1, 0, 1, 8,  1, 5'b01100);
        applyStimulus("branchIdle",     0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
        applyStimulus("multIssue2",     0, 1, 0,  0, 0, 1, 0, 0, 0,  0, 5'b00010);
        applyStimulus("busyRun",        0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00001);
        applyStimulus("resetBusy",      1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00001);
        applyStimulus("mfhiAfterRst",   0, 1, 0,  0, 0, 0, 1, 0, 0,  0, 5'b00000);
        applyStimulus("multIssue3",     0, 1, 0,  0, 0, 1, 0, 0, 0,  0, 5'b00010);
        applyStimulus("branchBusy",     0, 1, 0,  0, 0, 0, 1, 0, 0,  1, 5'b01101);
        for (int i = 0; i < 3; i++)
            applyStimulus("mfloStall2", 0, 1, 0,  0, 0, 0, 1, 0, 0,  0, 5'b11001);
        applyStimulus("multReissue",    0, 1, 0,  0, 0, 1, 0, 0, 0,  0, 5'b00010);
        applyStimulus("busyRun2",       0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00001);
        applyStimulus("dualHazard",     0, 1, 8,  0, 0, 1, 0, 1, 8,  0, 5'b11001);
        applyStimulus("busyRun3",       0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00001);
        applyStimulus("busyRun4",       0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00001);
        applyStimulus("busyDone",       0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
`ifdef STALL_STATS_EN
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++)
            applyStimulus("satFill",    0, 1, 8,  0, 0, 0, 0, 1, 8,  0, 5'b11000);
        quiet = 1'b0;
        applyStimulus("saturate",       0, 1, 8,  0, 0, 0, 0, 1, 8,  0, 5'b11000);
        applyStimulus("saturateHold",   0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 5'b00000);
`endif
        for (int i = 0; i < 20 && outQ.size() > 0; i++) @(negedge Clk);
        @(negedge Clk);
        if (outQ.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain pending %0d want 0", outQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_scheduler.md
Name: pipeline_stall_scheduler

Overview:
Hazard and stall scheduler for the 5-stage MIPS pipeline. It detects load-use hazards between the EX and ID stages and sequences the multi-cycle MULT/DIV unit through a small busy FSM. It drives PC/IF-ID hold, the ID/EX bubble, the IF/ID flush and the mult/div start pulse. It sits beside the EX/WB forwarding logic and covers the hazards that forwarding cannot resolve.

Parameters:
MULDIV_LATENCY, 4, cycles the mult/div unit stays busy after the start cycle; legal range 1..15.
CNT_W, 16, width of the stall statistics counter.

Ports:
Clk  input  1  pipeline clock, all state updates on the rising edge
Rst  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  5  ID source register rs
id_rt  input  5  ID source register rt
id_uses_rt  input  1  ID instruction reads rt as a source
id_is_muldiv  input  1  ID instruction is MULT/MULTU/DIV/DIVU
id_reads_hilo  input  1  ID instruction is MFHI/MFLO
ex_memRead  input  1  EX instruction is a load
ex_regDst  input  5  EX destination register
ex_branch_taken  input  1  branch or jump resolved taken in EX
stall  output  1  hold PC and IF/ID this cycle
id_ex_bubble  output  1  insert NOP into ID/EX this cycle
if_id_flush  output  1  clear IF/ID this cycle
muldiv_start  output  1  one-cycle launch pulse to the mult/div unit
muldiv_busy  output  1  mult/div unit operating (registered)
stall_count  output  CNT_W  cycles with stall asserted

Behaviour:
- Reset (Rst=1 at an edge): FSM goes to IDLE, busy counter 0, muldiv_busy 0, stall_count 0. Combinational outputs are 0 while FSM is IDLE and inputs are idle.
- lu_hazard = id_valid & ex_memRead & (ex_regDst != 0) & ((ex_regDst == id_rs) | (id_uses_rt & (ex_regDst == id_rt))). A register-0 destination never stalls.
- md_hazard = id_valid & muldiv_busy & (id_reads_hilo | id_is_muldiv).
- Priority, highest first:
  1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, stall=0, muldiv_start=0. The wrong-path ID instruction is killed.
  2. lu_hazard or md_hazard: stall=1, id_ex_bubble=1, muldiv_start=0.
  3. Otherwise, if id_valid & id_is_muldiv & FSM IDLE: muldiv_start=1.
- stall, id_ex_bubble, if_id_flush and muldiv_start are combinational, with zero latency in the same cycle.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX on the next edge.
- FSM states IDLE and BUSY:
  - IDLE to BUSY on an edge where muldiv_start=1; the counter loads MULDIV_LATENCY-1.
  - In BUSY, the counter decrements each edge. BUSY to IDLE on the edge where the counter equals 0.
  - muldiv_busy = (state == BUSY). It is high for exactly MULDIV_LATENCY cycles following the start cycle.
- MFHI/MFLO or a new mult/div instruction in ID during BUSY stalls until the first cycle muldiv_busy=0. A new mult/div instruction may issue in that same cycle.
- Taken branch while BUSY: flush proceeds and the FSM keeps counting. The in-flight mult/div is never cancelled.
- Rst while BUSY: IDLE on that edge; muldiv_busy=0 the next cycle.
- Simultaneous lu_hazard and md_hazard: a single stall; no double counting.

Optional Feature:
STALL_STATS_EN defined:
- stall_count increments on each edge where stall=1 and Rst=0.
- Saturates at all ones; no wrap.
- Cleared by Rst.
STALL_STATS_EN undefined:
- stall_count is tied to 0 and no counter register exists.

Test Plan:
- Load-use on rs: ex_memRead=1, ex_regDst=8, id_rs=8, id_valid=1. Required: stall=1 and id_ex_bubble=1 for 1 cycle; the same stimulus with ex_regDst=0 gives stall=0.
- rt gating: ex_regDst=9, id_rt=9, id_uses_rt=0 gives no stall; with id_uses_rt=1 gives stall=1.
- MULT issue then MFLO (MULDIV_LATENCY=4). Required: muldiv_start pulses 1 cycle, muldiv_busy=1 for 4 cycles, MFLO stalled 4 cycles, issuing in the cycle muldiv_busy falls.
- Branch priority: ex_branch_taken=1 together with lu_hazard and id_is_muldiv. Required: if_id_flush=1, id_ex_bubble=1, stall=0, muldiv_start=0, FSM stays IDLE.
- Reset mid-busy: Rst=1 two cycles after start. Required: muldiv_busy=0 the next cycle, stall_count=0, and a subsequent MFHI does not stall.
- STALL_STATS_EN: 3 load-use stalls plus a 4-cycle MFLO stall give stall_count=7. Forcing the counter near its maximum shows saturation at 0xFFFF.
